// File: rtl/c1355_misr_checker_if.sv
// Handshake bundle between a response source and the c1355 MISR checker.
// master: drives start/num_patterns/golden/resp_valid/resp, reads status.
// slave : the checker; reads the controls and response, drives
//         busy/done/pass/signature/count.
interface c1355_misr_checker_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic             start;
    logic [CNT_W-1:0] num_patterns;
    logic [WIDTH-1:0] golden;
    logic             resp_valid;
    logic [WIDTH-1:0] resp;
    logic             busy;
    logic             done;
    logic             pass;
    logic [WIDTH-1:0] signature;
    logic [CNT_W-1:0] count;

    modport master (
        output start,
        output num_patterns,
        output golden,
        output resp_valid,
        output resp,
        input  busy,
        input  done,
        input  pass,
        input  signature,
        input  count
    );

    modport slave (
        input  start,
        input  num_patterns,
        input  golden,
        input  resp_valid,
        input  resp,
        output busy,
        output done,
        output pass,
        output signature,
        output count
    );
endinterface

// File: rtl/c1355_misr_checker.sv
// Response compactor for the c1355 top: folds one WIDTH-bit response per
// valid cycle into a Galois MISR over a programmed pattern count, then
// compares the final signature against a golden value.
// Ports: clock, reset (sync, active-high), bus (c1355_misr_checker_if.slave):
//   start/num_patterns/golden/resp_valid/resp in,
//   busy/done/pass/signature/count out.
module c1355_misr_checker #(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] POLY    = 32'h04C11DB7,
    parameter logic [WIDTH-1:0] SEED    = 32'h00000000,
    parameter int               CNT_W   = 16,
    parameter int               FLUSH_N = 0
) (
    input logic                 clock,
    input logic                 reset,
    c1355_misr_checker_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Flush counter is at least one bit wide so FLUSH_N=0 still elaborates;
    // the FLUSH state is simply unreachable in that case.
    localparam int FL_W = (FLUSH_N > 1) ? $clog2(FLUSH_N) : 1;
    localparam logic [FL_W-1:0] FL_LAST =
        FL_W'((FLUSH_N > 0) ? (FLUSH_N - 1) : 0);

    state_t           state, state_n;
    logic [WIDTH-1:0] sig, sig_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CNT_W-1:0] num, num_n;
    logic [WIDTH-1:0] gold, gold_n;
    logic             pass_r, pass_n;
    logic [FL_W-1:0]  fcnt, fcnt_n;

    logic [WIDTH-1:0] fb;
    logic [WIDTH-1:0] mix;
    logic [CNT_W-1:0] cnt_inc;

    // Galois shift-left step with the response folded in.
    assign fb      = sig[WIDTH-1] ? POLY : '0;
    assign mix     = {sig[WIDTH-2:0], 1'b0} ^ fb ^ bus.resp;
    assign cnt_inc = cnt + 1'b1;

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            sig    <= SEED;
            cnt    <= '0;
            num    <= '0;
            gold   <= '0;
            pass_r <= 1'b0;
            fcnt   <= '0;
        end else begin
            state  <= state_n;
            sig    <= sig_n;
            cnt    <= cnt_n;
            num    <= num_n;
            gold   <= gold_n;
            pass_r <= pass_n;
            fcnt   <= fcnt_n;
        end
    end

    always_comb begin
        state_n = state;
        sig_n   = sig;
        cnt_n   = cnt;
        num_n   = num;
        gold_n  = gold;
        pass_n  = pass_r;
        fcnt_n  = fcnt;

        unique case (state)
            IDLE, DONE: begin
                // A response arriving with start is deliberately dropped.
                if (bus.start) begin
                    num_n  = bus.num_patterns;
                    gold_n = bus.golden;
                    sig_n  = SEED;
                    cnt_n  = '0;
                    fcnt_n = '0;
                    pass_n = 1'b0;
                    if (bus.num_patterns == '0) begin
                        state_n = DONE;
                        pass_n  = (SEED == bus.golden);
                    end else if (FLUSH_N > 0) begin
                        state_n = FLUSH;
                    end else begin
                        state_n = RUN;
                    end
                end
            end

            FLUSH: begin
                if (bus.resp_valid) begin
                    if (fcnt == FL_LAST) begin
                        fcnt_n  = '0;
                        state_n = RUN;
                    end else begin
                        fcnt_n = fcnt + 1'b1;
                    end
                end
            end

            RUN: begin
                if (bus.resp_valid) begin
                    sig_n = mix;
                    cnt_n = cnt_inc;
                    if (cnt_inc == num) begin
                        state_n = DONE;
                        pass_n  = (mix == gold);
                    end
                end
            end

            default: state_n = IDLE;
        endcase
    end

    assign bus.busy      = (state == FLUSH) || (state == RUN);
    assign bus.done      = (state == DONE);
    assign bus.pass      = pass_r;
    assign bus.signature = sig;
    assign bus.count     = cnt;

endmodule

// File: tb/tb_c1355_misr_checker.sv
// Self-checking bench for c1355_misr_checker: directed cases plus random
// runs, final results checked through a scoreboard queue.
module tb_c1355_misr_checker;

    localparam logic [31:0] POLY = 32'h04C11DB7;

    typedef struct {
        logic [31:0] sig;
        logic        pass;
        logic [15:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t q1[$];
    exp_t q2[$];
    logic done1_q = 1'b0;
    logic done2_q = 1'b0;

    c1355_misr_checker_if #(.WIDTH(32), .CNT_W(16)) ifc ();
    c1355_misr_checker_if #(.WIDTH(32), .CNT_W(16)) ifc2 ();

    c1355_misr_checker #(.FLUSH_N(0)) dut (
        .clock(clk),
        .reset(rst),
        .bus  (ifc.slave)
    );

    c1355_misr_checker #(.FLUSH_N(1)) dut2 (
        .clock(clk),
        .reset(rst),
        .bus  (ifc2.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] misr(input logic [31:0] s,
                                         input logic [31:0] r);
        return {s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0) ^ r;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic start_run(input logic [15:0] n, input logic [31:0] g);
        ifc.start = 1'b1;
        ifc.num_patterns = n;
        ifc.golden = g;
        step();
        ifc.start = 1'b0;
        ifc.num_patterns = 16'h0;
        ifc.golden = 32'h0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (ifc.done && !done1_q) begin
            if (q1.size() == 0) begin
                check("sb1_empty", 32'd1, 32'd0);
            end else begin
                e = q1.pop_front();
                check("sb1_sig", ifc.signature, e.sig);
                check("sb1_pass", {31'b0, ifc.pass}, {31'b0, e.pass});
                check("sb1_cnt", {16'b0, ifc.count}, {16'b0, e.cnt});
            end
        end
        done1_q = ifc.done;
    end

    always @(negedge clk) begin
        exp_t e;
        if (ifc2.done && !done2_q) begin
            if (q2.size() == 0) begin
                check("sb2_empty", 32'd1, 32'd0);
            end else begin
                e = q2.pop_front();
                check("sb2_sig", ifc2.signature, e.sig);
                check("sb2_pass", {31'b0, ifc2.pass}, {31'b0, e.pass});
                check("sb2_cnt", {16'b0, ifc2.count}, {16'b0, e.cnt});
            end
        end
        done2_q = ifc2.done;
    end

    initial begin
        logic [31:0] s;
        logic [31:0] d[$];
        int          n;
        int          sent;

        ifc.start = 1'b0;
        ifc.num_patterns = 16'h0;
        ifc.golden = 32'h0;
        ifc.resp_valid = 1'b0;
        ifc.resp = 32'h0;
        ifc2.start = 1'b0;
        ifc2.num_patterns = 16'h0;
        ifc2.golden = 32'h0;
        ifc2.resp_valid = 1'b0;
        ifc2.resp = 32'h0;

        step();
        step();
        rst = 1'b0;
        check("rst_busy", {31'b0, ifc.busy}, 32'd0);
        check("rst_done", {31'b0, ifc.done}, 32'd0);
        check("rst_pass", {31'b0, ifc.pass}, 32'd0);
        check("rst_sig", ifc.signature, 32'h0);
        check("rst_cnt", {16'b0, ifc.count}, 32'd0);

        // Two ones: signature 1 then 3, golden matches.
        q1.push_back('{sig: 32'h3, pass: 1'b1, cnt: 16'd2});
        start_run(16'd2, 32'h3);
        check("t2_busy", {31'b0, ifc.busy}, 32'd1);
        ifc.resp_valid = 1'b1;
        ifc.resp = 32'h1;
        step();
        check("t2_sig1", ifc.signature, 32'h1);
        check("t2_done_early", {31'b0, ifc.done}, 32'd0);
        step();
        ifc.resp_valid = 1'b0;
        check("t2_sig2", ifc.signature, 32'h3);
        check("t2_done", {31'b0, ifc.done}, 32'd1);
        check("t2_busy_end", {31'b0, ifc.busy}, 32'd0);

        // Same data, wrong golden; restart from DONE drops done.
        q1.push_back('{sig: 32'h3, pass: 1'b0, cnt: 16'd2});
        start_run(16'd2, 32'h4);
        check("t2b_done_drop", {31'b0, ifc.done}, 32'd0);
        ifc.resp_valid = 1'b1;
        ifc.resp = 32'h1;
        step();
        step();
        ifc.resp_valid = 1'b0;
        check("t2b_pass", {31'b0, ifc.pass}, 32'd0);

        // Feedback tap.
        q1.push_back('{sig: POLY, pass: 1'b1, cnt: 16'd2});
        start_run(16'd2, POLY);
        ifc.resp_valid = 1'b1;
        ifc.resp = 32'h80000000;
        step();
        check("t3_sig1", ifc.signature, 32'h80000000);
        ifc.resp = 32'h0;
        step();
        ifc.resp_valid = 1'b0;
        check("t3_sig2", ifc.signature, 32'h04C11DB7);

        // Reset mid-run after three samples.
        start_run(16'd10, 32'h0);
        ifc.resp_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ifc.resp = $urandom;
            step();
        end
        ifc.resp_valid = 1'b0;
        check("t1_cnt3", {16'b0, ifc.count}, 32'd3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t1_busy", {31'b0, ifc.busy}, 32'd0);
        check("t1_done", {31'b0, ifc.done}, 32'd0);
        check("t1_sig", ifc.signature, 32'h0);
        check("t1_cnt", {16'b0, ifc.count}, 32'd0);

        // resp_valid in IDLE is ignored.
        ifc.resp_valid = 1'b1;
        ifc.resp = 32'hA5A5_5A5A;
        step();
        step();
        ifc.resp_valid = 1'b0;
        check("t5_idle_sig", ifc.signature, 32'h0);
        check("t5_idle_cnt", {16'b0, ifc.count}, 32'd0);

        // Zero patterns: done next cycle, busy never raised.
        q1.push_back('{sig: 32'h0, pass: 1'b1, cnt: 16'd0});
        start_run(16'd0, 32'h0);
        check("t4_done", {31'b0, ifc.done}, 32'd1);
        check("t4_busy", {31'b0, ifc.busy}, 32'd0);
        check("t4_pass", {31'b0, ifc.pass}, 32'd1);
        step();
        check("t4_busy2", {31'b0, ifc.busy}, 32'd0);
        check("t4_hold", {31'b0, ifc.done}, 32'd1);

        // Three samples with bubbles and a stray start mid-run.
        d.delete();
        for (int i = 0; i < 3; i++) d.push_back($urandom);
        s = 32'h0;
        foreach (d[i]) s = misr(s, d[i]);
        q1.push_back('{sig: s, pass: 1'b1, cnt: 16'd3});
        start_run(16'd3, s);
        ifc.resp_valid = 1'b1;
        ifc.resp = d[0];
        step();
        ifc.resp_valid = 1'b0;
        ifc.resp = 32'hFFFF_FFFF;
        ifc.start = 1'b1;
        ifc.num_patterns = 16'd1;
        ifc.golden = 32'h1234;
        step();
        ifc.start = 1'b0;
        step();
        check("t5_gap_cnt", {16'b0, ifc.count}, 32'd1);
        check("t5_gap_busy", {31'b0, ifc.busy}, 32'd1);
        ifc.resp_valid = 1'b1;
        ifc.resp = d[1];
        step();
        ifc.resp_valid = 1'b0;
        step();
        ifc.resp_valid = 1'b1;
        ifc.resp = d[2];
        step();
        ifc.resp_valid = 1'b0;
        check("t5_done", {31'b0, ifc.done}, 32'd1);

        // Sample coincident with start is not compacted.
        d.delete();
        d.push_back($urandom);
        d.push_back($urandom);
        s = misr(32'h0, d[1]);
        q1.push_back('{sig: s, pass: 1'b1, cnt: 16'd1});
        ifc.resp_valid = 1'b1;
        ifc.resp = d[0];
        start_run(16'd1, s);
        ifc.resp = d[1];
        step();
        ifc.resp_valid = 1'b0;

        // Random runs with random bubbles.
        for (int k = 0; k < 4; k++) begin
            n = $urandom_range(1, 6);
            d.delete();
            for (int i = 0; i < n; i++) d.push_back($urandom);
            s = 32'h0;
            foreach (d[i]) s = misr(s, d[i]);
            q1.push_back('{sig: s, pass: k[0], cnt: 16'(n)});
            start_run(16'(n), k[0] ? s : s ^ 32'h1);
            sent = 0;
            while (sent < n) begin
                ifc.resp_valid = ($urandom_range(0, 2) != 0);
                ifc.resp = ifc.resp_valid ? d[sent] : $urandom;
                if (ifc.resp_valid) sent++;
                step();
            end
            ifc.resp_valid = 1'b0;
            check("rnd_done", {31'b0, ifc.done}, 32'd1);
        end

        // Integration: all-zero c1355 inputs give all-zero responses;
        // the first valid sample is pipeline fill and must be flushed.
        for (int r = 0; r < 2; r++) begin
            s = 32'h0;
            for (int i = 0; i < 8; i++)
                s = misr(s, (r == 1 && i == 3) ? 32'h20 : 32'h0);
            q2.push_back('{sig: s, pass: (s == 32'h0), cnt: 16'd8});
            ifc2.start = 1'b1;
            ifc2.num_patterns = 16'd8;
            ifc2.golden = 32'h0;
            step();
            ifc2.start = 1'b0;
            ifc2.resp_valid = 1'b1;
            ifc2.resp = 32'hDEAD_BEEF;
            step();
            check("t6_flush_cnt", {16'b0, ifc2.count}, 32'd0);
            check("t6_flush_sig", ifc2.signature, 32'h0);
            for (int i = 0; i < 8; i++) begin
                ifc2.resp = (r == 1 && i == 3) ? 32'h20 : 32'h0;
                step();
            end
            ifc2.resp_valid = 1'b0;
            check("t6_pass", {31'b0, ifc2.pass}, (r == 0) ? 32'd1 : 32'd0);
        end

        step();
        step();
        check("sb1_left", q1.size(), 32'd0);
        check("sb2_left", q2.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
